// File: rtl/dsp_reg_wbq.sv
// dsp_reg_wbq: write-back queue and operand-forwarding front end for the
// 64x32 dual-port DSP register file.
// Queued result writes drain to the RAM in cycles that carry no accepted
// operand read. Operands come back one cycle after an accepted read. If a
// newer value for a source register is still queued, or is being written in
// the same cycle, that value is forwarded instead of the RAM data.
// Optional feature macro: DSP_WBQ_DUAL_DRAIN_EN. When it is defined, a drain
// cycle also retires the entry after the head on port B, provided its address
// differs from the head's.
module dsp_reg_wbq #(
   parameter int DEPTH = 4,
   parameter int AW    = 6,
   parameter int DW    = 32
) (
   input  logic          sys_clk_i,
   input  logic          reset_i,
   input  logic          wr_valid_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   output logic          wr_ready_o,
   input  logic          rd_req_i,
   input  logic [AW-1:0] rd_src1_i,
   input  logic [AW-1:0] rd_src2_i,
   output logic          rd_ready_o,
   output logic [DW-1:0] op1_o,
   output logic [DW-1:0] op2_o,
   output logic          op_valid_o,
   output logic [AW-1:0] aa_o,
   output logic [AW-1:0] ab_o,
   output logic [DW-1:0] da_o,
   output logic [DW-1:0] db_o,
   output logic          nwea_o,
   output logic          nweb_o,
   output logic          clka_o,
   output logic          clkb_o,
   input  logic [DW-1:0] qa_i,
   input  logic [DW-1:0] qb_i,
   output logic          empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0] qaddr_q [DEPTH];
   logic [DW-1:0] qdata_q [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d, head1;
   logic [CW-1:0] count_q, count_d, pop_n;
   logic          not_full, rd_acc, wr_acc, drain, dual;
   logic          pend_q;
   logic          hit1_q, hit1_d, hit2_q, hit2_d;
   logic [DW-1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;
   logic [DW-1:0] op1_q, op2_q;
   logic [PW-1:0] fwd_idx;

   assign not_full   = (count_q < CW'(DEPTH));
   assign wr_ready_o = not_full;
   assign rd_ready_o = not_full;
   assign empty_o    = (count_q == '0);
   // Port enables must stay low while reset is held, even if rd_req is high.
   assign rd_acc     = rd_req_i & not_full & ~reset_i;
   assign wr_acc     = wr_valid_i & not_full;
   assign drain      = ~rd_acc & (count_q != '0);
   assign head1      = head_q + PW'(1);

`ifdef DSP_WBQ_DUAL_DRAIN_EN
   // Two writes to the same register in one cycle would race in the RAM,
   // so a duplicate address falls back to a single-entry drain.
   assign dual = drain & (count_q >= CW'(2)) & (qaddr_q[head1] != qaddr_q[head_q]);
`else
   assign dual = 1'b0;
`endif

   assign pop_n = drain ? (dual ? CW'(2) : CW'(1)) : '0;

   // Pointer and occupancy update for simultaneous push and pop.
   always_comb begin
      tail_d  = wr_acc ? tail_q + PW'(1) : tail_q;
      head_d  = head_q + pop_n[PW-1:0];
      count_d = count_q + CW'(wr_acc) - pop_n;
   end

   // Forwarding search, oldest to newest, so later matches override earlier ones.
   always_comb begin
      hit1_d  = 1'b0;
      hit2_d  = 1'b0;
      fwd1_d  = '0;
      fwd2_d  = '0;
      fwd_idx = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = head_q + PW'(i);
         if (CW'(i) < count_q) begin
            if (qaddr_q[fwd_idx] == rd_src1_i) begin
               hit1_d = 1'b1;
               fwd1_d = qdata_q[fwd_idx];
            end
            if (qaddr_q[fwd_idx] == rd_src2_i) begin
               hit2_d = 1'b1;
               fwd2_d = qdata_q[fwd_idx];
            end
         end
      end
      if (wr_acc && (wr_addr_i == rd_src1_i)) begin
         hit1_d = 1'b1;
         fwd1_d = wr_data_i;
      end
      if (wr_acc && (wr_addr_i == rd_src2_i)) begin
         hit2_d = 1'b1;
         fwd2_d = wr_data_i;
      end
   end

   // RAM port drive: an accepted read owns both ports, otherwise drain the head.
   always_comb begin
      aa_o   = qaddr_q[head_q];
      da_o   = qdata_q[head_q];
      ab_o   = qaddr_q[head1];
      db_o   = qdata_q[head1];
      nwea_o = 1'b1;
      nweb_o = 1'b1;
      clka_o = 1'b0;
      clkb_o = 1'b0;
      if (rd_acc) begin
         aa_o   = rd_src1_i;
         ab_o   = rd_src2_i;
         clka_o = 1'b1;
         clkb_o = 1'b1;
      end else if (drain) begin
         nwea_o = 1'b0;
         clka_o = 1'b1;
         if (dual) begin
            nweb_o = 1'b0;
            clkb_o = 1'b1;
         end
      end
   end

   assign op_valid_o = pend_q;
   assign op1_o      = pend_q ? (hit1_q ? fwd1_q : qa_i) : op1_q;
   assign op2_o      = pend_q ? (hit2_q ? fwd2_q : qb_i) : op2_q;

   // Control state, forwarding capture and operand hold registers.
   always_ff @(posedge sys_clk_i or posedge reset_i) begin
      if (reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         pend_q  <= 1'b0;
         hit1_q  <= 1'b0;
         hit2_q  <= 1'b0;
         fwd1_q  <= '0;
         fwd2_q  <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         pend_q  <= rd_acc;
         if (rd_acc) begin
            hit1_q <= hit1_d;
            hit2_q <= hit2_d;
            fwd1_q <= fwd1_d;
            fwd2_q <= fwd2_d;
         end
         if (pend_q) begin
            op1_q <= op1_o;
            op2_q <= op2_o;
         end
      end
   end

   // Entry storage; no reset is needed because the count marks which entries are live.
   always_ff @(posedge sys_clk_i) begin
      if (wr_acc) begin
         qaddr_q[tail_q] <= wr_addr_i;
         qdata_q[tail_q] <= wr_data_i;
      end
   end

endmodule
